bitmanip_seq_unit: RTL and testbench



---
 rtl/bitmanip_pkg.sv | 36 +++
 rtl/bitmanip_seq_unit_if.sv | 23 ++
 rtl/bitmanip_chunk_step.sv | 49 ++++
 rtl/bitmanip_seq_unit.sv | 140 ++++++++++++++
 tb/tb_bitmanip_seq_unit.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/bitmanip_pkg.sv
// Shared opcode/state encodings and legality check for the bit-manipulation sequencer.
// BITMANIP_BSWAP_EN makes opcode 4 (byte swap) legal.
package bitmanip_pkg;

   typedef enum logic [2:0] {
      OP_REV    = 3'd0,
      OP_POPCNT = 3'd1,
      OP_CLZ    = 3'd2,
      OP_CTZ    = 3'd3,
      OP_BSWAP  = 3'd4
   } bitmanip_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } bitmanip_state_e;

   function automatic logic is_legal_op(input logic [2:0] op);
`ifdef BITMANIP_BSWAP_EN
      return (op <= 3'd4);
`else
      return (op <= 3'd3);
`endif
   endfunction

   // Ops that finish in IDLE without any chunk passes.
   function automatic logic is_direct_op(input logic [2:0] op);
`ifdef BITMANIP_BSWAP_EN
      return !is_legal_op(op) || (op == 3'd4);
`else
      return !is_legal_op(op);
`endif
   endfunction

endpackage

// File: rtl/bitmanip_seq_unit_if.sv
// Request/response valid-ready bundle between the issuing stage and bitmanip_seq_unit.
interface bitmanip_seq_unit_if #(
   parameter int WIDTH = 64
);
   logic             req_valid;
   logic             req_ready;
   logic [2:0]       req_op;
   logic [WIDTH-1:0] req_operand;
   logic             resp_valid;
   logic             resp_ready;
   logic [WIDTH-1:0] resp_result;
   logic             resp_err;

   modport master (
      output req_valid, req_op, req_operand, resp_ready,
      input  req_ready, resp_valid, resp_result, resp_err
   );

   modport slave (
      input  req_valid, req_op, req_operand, resp_ready,
      output req_ready, resp_valid, resp_result, resp_err
   );
endinterface

// File: rtl/bitmanip_chunk_step.sv
// Combinational per-chunk primitives: popcount, leading/trailing zero counts,
// any-one detect and bit-reversed chunk.
module bitmanip_chunk_step #(
   parameter int CHUNK = 8,
   parameter int CNTW  = $clog2(CHUNK + 1)
) (
   input  logic [CHUNK-1:0] chunk,
   output logic [CNTW-1:0]  popcnt,
   output logic [CNTW-1:0]  lzc,
   output logic [CNTW-1:0]  tzc,
   output logic             has_one,
   output logic [CHUNK-1:0] rev
);

   always_comb begin
      popcnt = '0;
      for (int i = 0; i < CHUNK; i++) begin
         popcnt = popcnt + CNTW'(chunk[i]);
         rev[i] = chunk[CHUNK-1-i];
      end
   end

   always_comb begin
      logic found;
      lzc   = '0;
      found = 1'b0;
      for (int i = CHUNK - 1; i >= 0; i--) begin
         if (!found) begin
            if (chunk[i]) found = 1'b1;
            else          lzc   = lzc + CNTW'(1);
         end
      end
   end

   always_comb begin
      logic found;
      tzc   = '0;
      found = 1'b0;
      for (int i = 0; i < CHUNK; i++) begin
         if (!found) begin
            if (chunk[i]) found = 1'b1;
            else          tzc   = tzc + CNTW'(1);
         end
      end
   end

   assign has_one = |chunk;

endmodule

// File: rtl/bitmanip_seq_unit.sv
// Multi-cycle bit-manipulation stage: REV/POPCNT/CLZ/CTZ at CHUNK bits per cycle.
// Optional macro BITMANIP_BSWAP_EN adds single-cycle byte swap (opcode 4).
module bitmanip_seq_unit
   import bitmanip_pkg::*;
#(
   parameter int WIDTH = 64,
   parameter int CHUNK = 8
) (
   input logic               clk,
   input logic               rst,
   bitmanip_seq_unit_if.slave bus
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam int CNTW   = $clog2(CHUNK + 1);

   localparam logic [1:0] IDLE = ST_IDLE;
   localparam logic [1:0] BUSY = ST_BUSY;
   localparam logic [1:0] DONE = ST_DONE;

   if (WIDTH % CHUNK != 0) begin : g_bad_chunk
      $error("bitmanip_seq_unit: WIDTH must be a multiple of CHUNK");
   end

`ifdef BITMANIP_BSWAP_EN
   if (WIDTH % 8 != 0) begin : g_bad_bswap
      $error("bitmanip_seq_unit: WIDTH must be a multiple of 8 for BSWAP");
   end

   function automatic logic [WIDTH-1:0] bswap(input logic [WIDTH-1:0] v);
      logic [WIDTH-1:0] r;
      r = '0;
      for (int b = 0; b < WIDTH / 8; b++) r[b*8 +: 8] = v[(WIDTH/8-1-b)*8 +: 8];
      return r;
   endfunction
`endif

   logic [1:0]       state;
   logic [2:0]       op_q;
   logic [WIDTH-1:0] operand_q;
   logic [WIDTH-1:0] acc;
   logic [CW-1:0]    cnt;
   logic [CW-1:0]    ridx;
   logic [CW-1:0]    sidx;
   logic             stop;
   logic             settle;
   logic             resp_valid_q;
   logic             resp_err_q;

   logic [CHUNK-1:0] chunk;
   logic [CHUNK-1:0] chunk_rev;
   logic [CNTW-1:0]  pc;
   logic [CNTW-1:0]  lzc;
   logic [CNTW-1:0]  tzc;
   logic             has_one;

   // CLZ walks chunks MSB-first; everything else LSB-first. REV lands mirrored.
   always_comb begin
      ridx  = CW'(NCHUNK - 1) - cnt;
      sidx  = (op_q == OP_CLZ) ? ridx : cnt;
      chunk = operand_q[sidx*CHUNK +: CHUNK];
   end

   bitmanip_chunk_step #(
      .CHUNK (CHUNK),
      .CNTW  (CNTW)
   ) u_step (
      .chunk   (chunk),
      .popcnt  (pc),
      .lzc     (lzc),
      .tzc     (tzc),
      .has_one (has_one),
      .rev     (chunk_rev)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         op_q         <= '0;
         operand_q    <= '0;
         acc          <= '0;
         cnt          <= '0;
         stop         <= 1'b0;
         settle       <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.req_valid) begin
                  op_q       <= bus.req_op;
                  operand_q  <= bus.req_operand;
                  acc        <= '0;
                  cnt        <= '0;
                  stop       <= 1'b0;
                  resp_err_q <= !is_legal_op(bus.req_op);
                  // Direct ops answer on the same cadence as a one-chunk pass.
                  settle     <= is_direct_op(bus.req_op);
                  state      <= is_direct_op(bus.req_op) ? DONE : BUSY;
`ifdef BITMANIP_BSWAP_EN
                  if (bus.req_op == OP_BSWAP) acc <= bswap(bus.req_operand);
`endif
               end
            end
            BUSY: begin
               case (op_q)
                  OP_REV:    acc[ridx*CHUNK +: CHUNK] <= chunk_rev;
                  OP_POPCNT: acc <= acc + WIDTH'(pc);
                  OP_CLZ, OP_CTZ: begin
                     if (!stop) begin
                        acc <= acc + WIDTH'((op_q == OP_CLZ) ? lzc : tzc);
                        if (has_one) stop <= 1'b1;
                     end
                  end
                  default: ;
               endcase
               if (cnt == CW'(NCHUNK - 1)) state <= DONE;
               else                        cnt   <= cnt + CW'(1);
            end
            DONE: begin
               if (!resp_valid_q) begin
                  if (settle) settle       <= 1'b0;
                  else        resp_valid_q <= 1'b1;
               end else if (bus.resp_ready) begin
                  resp_valid_q <= 1'b0;
                  state        <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.req_ready   = (state == IDLE) && !rst;
   assign bus.resp_valid  = resp_valid_q;
   assign bus.resp_result = acc;
   assign bus.resp_err    = resp_err_q;

endmodule

// File: tb/tb_bitmanip_seq_unit.sv
// Randomized + directed bench for bitmanip_seq_unit (WIDTH=16, CHUNK=4) against a behavioural model.
module tb_bitmanip_seq_unit;

   localparam int W = 16;
   localparam int C = 4;
   localparam int N = W / C;

   typedef struct {
      logic [W-1:0] res;
      logic         err;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   bitmanip_seq_unit_if #(.WIDTH(W)) bus ();

   bitmanip_seq_unit #(.WIDTH(W), .CHUNK(C)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int   checks = 0;
   int   errors = 0;
   exp_t expq[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] v);
      exp_t e;
      int   n;
      e.res = '0;
      e.err = 1'b0;
      n     = 0;
      case (op)
         3'd0: for (int i = 0; i < W; i++) e.res[W-1-i] = v[i];
         3'd1: e.res = W'($countones(v));
         3'd2: begin
            while (n < W && v[W-1-n] == 1'b0) n++;
            e.res = W'(n);
         end
         3'd3: begin
            while (n < W && v[n] == 1'b0) n++;
            e.res = W'(n);
         end
`ifdef BITMANIP_BSWAP_EN
         3'd4: for (int b = 0; b < W / 8; b++) e.res[b*8 +: 8] = v[(W/8-1-b)*8 +: 8];
`endif
         default: e.err = 1'b1;
      endcase
      return e;
   endfunction

   // Compare process: every meaningful response cycle against the expectation queue.
   always @(negedge clk) begin
      if (rst) begin
         chk("req_ready_in_reset", 32'(bus.req_ready), 32'd0);
      end else if (bus.resp_valid) begin
         if (expq.size() == 0) begin
            chk("unexpected_resp_valid", 32'(bus.resp_valid), 32'd0);
         end else begin
            chk("resp_result", 32'(bus.resp_result), 32'(expq[0].res));
            chk("resp_err", 32'(bus.resp_err), 32'(expq[0].err));
            if (bus.resp_ready) void'(expq.pop_front());
         end
      end
   end

   task automatic do_txn(input logic [2:0] op, input logic [W-1:0] v, input int hold);
      exp_t e;
      int   edges;
      int   lat;
      e   = model(op, v);
      lat = (e.err || op == 3'd4) ? 2 : N + 1;
      @(negedge clk);
      chk("req_ready_idle", 32'(bus.req_ready), 32'd1);
      bus.req_valid   = 1'b1;
      bus.req_op      = op;
      bus.req_operand = v;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      expq.push_back(e);
      chk("req_ready_after_accept", 32'(bus.req_ready), 32'd0);
      edges = 0;
      while (!bus.resp_valid && edges < 20) begin
         @(posedge clk);
         #1;
         edges++;
      end
      chk("latency", 32'(edges), 32'(lat));
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         #1;
         chk("hold_resp_valid", 32'(bus.resp_valid), 32'd1);
         chk("hold_req_ready", 32'(bus.req_ready), 32'd0);
      end
      bus.resp_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.resp_ready = 1'b0;
      chk("post_hs_resp_valid", 32'(bus.resp_valid), 32'd0);
      chk("post_hs_req_ready", 32'(bus.req_ready), 32'd1);
   endtask

   initial begin
      exp_t       e;
      logic [2:0] rop;
      logic [W-1:0] rv;
      bus.req_valid   = 1'b0;
      bus.req_op      = '0;
      bus.req_operand = '0;
      bus.resp_ready  = 1'b0;

      // Pin the model to hand-computed values.
      e = model(3'd0, 16'hA442); chk("model_rev", 32'(e.res), 32'h4225);
      e = model(3'd1, 16'hA442); chk("model_pop", 32'(e.res), 32'd5);
      e = model(3'd2, 16'h00F0); chk("model_clz", 32'(e.res), 32'd8);
      e = model(3'd3, 16'h8000); chk("model_ctz", 32'(e.res), 32'd15);
      e = model(3'd6, 16'h1234); chk("model_illegal", 32'({e.err, e.res}), 32'h10000);
`ifdef BITMANIP_BSWAP_EN
      e = model(3'd4, 16'h1234); chk("model_bswap", 32'({e.err, e.res}), 32'h03412);
`else
      e = model(3'd4, 16'h1234); chk("model_bswap_off", 32'({e.err, e.res}), 32'h10000);
`endif

      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
      chk("rst_resp_result", 32'(bus.resp_result), 32'd0);
      chk("rst_resp_err", 32'(bus.resp_err), 32'd0);
      chk("rst_req_ready", 32'(bus.req_ready), 32'd1);

      do_txn(3'd0, 16'hA442, 0);
      do_txn(3'd1, 16'hA442, 1);
      do_txn(3'd2, 16'h00F0, 0);
      do_txn(3'd3, 16'h00F0, 0);
      do_txn(3'd2, 16'h0000, 0);
      do_txn(3'd3, 16'h0000, 0);
      do_txn(3'd3, 16'h8000, 0);
      do_txn(3'd0, 16'h0001, 10);
      do_txn(3'd6, 16'hBEEF, 0);
      do_txn(3'd4, 16'h1234, 0);

      // Reset during the second BUSY cycle of a POPCNT aborts it silently.
      @(negedge clk);
      bus.req_valid   = 1'b1;
      bus.req_op      = 3'd1;
      bus.req_operand = 16'hFFFF;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      chk("abort_req_ready", 32'(bus.req_ready), 32'd1);
      do_txn(3'd0, 16'h00FF, 0);

      for (int t = 0; t < 60; t++) begin
         rop = 3'($urandom_range(0, 7));
         case ($urandom_range(0, 3))
            0:       rv = '0;
            1:       rv = W'(1) << $urandom_range(0, W - 1);
            default: rv = W'($urandom);
         endcase
         do_txn(rop, rv, $urandom_range(0, 3));
      end

      @(negedge clk);
      chk("queue_drained", 32'(expq.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
